reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- In-order commit queue for the out-of-order core.
- Allocates ROB tags (ROBENs) to decoded instructions and drives the register file's Decoded_WP1_* tag-write port.
- Captures results broadcast on the CDB and retires the oldest entry through the register file's WP1_* commit port.
- Tag 0 means "no producer / value in register file" and is never allocated.

Parameters:
- DEPTH, 15, number of entries; tags 1..DEPTH; legal range 2..31.
- TAG_W, 5, ROBEN width; fixed to 5 to match the register file.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all in-flight entries
- alloc_req  in  1  decode requests an entry
- alloc_Wen  in  1  instruction writes a destination register
- alloc_DRindex  in  5  destination register index
- alloc_ready  out  1  an entry is free (!full)
- Decoded_WP1_Wen  out  1  tag write to register file
- Decoded_WP1_ROBEN  out  5  allocated tag (tail)
- Decoded_WP1_DRindex  out  5  equals alloc_DRindex
- CDB_valid  in  1  result broadcast
- CDB_ROBEN  in  5  producing tag
- CDB_Data  in  32  result value
- RP_ROBEN1, RP_ROBEN2  in  5  operand tag lookup
- RP_ready1, RP_ready2  out  1  looked-up value available
- RP_Data1, RP_Data2  out  32  looked-up value
- commit_valid  out  1  head retires this cycle
- WP1_Wen  out  1  register write at commit
- WP1_ROBEN  out  5  head tag
- WP1_DRindex  out  5  head destination
- WP1_Data  out  32  head value
- full, empty  out  1  status
- count  out  5  occupied entries
- commit_count  out  32  retired-instruction counter (optional feature)

Behaviour:
- Reset:
  - rst is synchronous, active-high, and has highest priority.
  - Clears all entry valid/ready bits; head = tail = 1; count = 0.
  - Post-reset outputs: empty = 1, full = 0, commit_valid = 0, WP1_Wen = 0.
  - A reset asserted mid-operation discards all entries in the same edge.
- Entry fields: valid, ready, Wen, DRindex[4:0], Data[31:0].
- Allocation:
  - Fires when alloc_req && alloc_ready.
  - Writes entry[tail] with valid = 1, ready = 0, Wen = alloc_Wen, DRindex = alloc_DRindex.
  - tail advances 1 → 2 → … → DEPTH → 1; tag 0 is skipped.
  - Decoded_WP1_ROBEN = tail (combinational).
  - Decoded_WP1_Wen = alloc_req && alloc_ready && alloc_Wen && alloc_DRindex != 0.
  - alloc_ready = !full. A commit in the same cycle does not free a slot for that cycle's allocation.
- CDB capture:
  - If CDB_valid and entry[CDB_ROBEN] is valid and not ready: Data = CDB_Data, ready = 1 at the edge.
  - A CDB to an invalid entry or tag 0 is ignored.
- Commit:
  - Combinational from registered head state; no input-to-output path.
  - commit_valid = entry[head].valid && entry[head].ready.
  - WP1_Wen = commit_valid && Wen && DRindex != 0.
  - WP1_ROBEN = head; WP1_DRindex and WP1_Data come from the head entry.
  - On the commit edge: head entry valid = 0, head advances with the same wrap rule.
  - Latency: a CDB write to the head commits the following cycle. At most one commit per cycle.
- Simultaneous events:
  - alloc + commit in one cycle: count unchanged.
  - CDB to the head in the same cycle it is examined: not committed until the next cycle.
- Operand lookup (combinational):
  - RP_ROBENx == 0 → ready = 1, data = 0.
  - CDB_valid && CDB_ROBEN == RP_ROBENx → ready = 1, data = CDB_Data (bypass).
  - Otherwise ready and data come from the entry.
- Flush:
  - Priority below rst, above all else.
  - Same clearing effect as reset, except commit_count is preserved.
  - Allocation, CDB capture and commit in a flush cycle are discarded.
  - The register-file tag table is cleared by its owner, not by this block.
- Status: full = (count == DEPTH); empty = (count == 0).

Optional Feature:
- Macro ROB_STATS_EN.
- Defined: commit_count increments on every commit_valid edge, wraps at 2^32, and is cleared only by rst.
- Undefined: commit_count is tied to 0 and no counter flop exists.

Test Plan:
- Reset then allocate 3 entries (DR 5, 6, 7) → Decoded_WP1_ROBEN 1, 2, 3; count = 3; commit_valid = 0.
- CDB tag 2 data 0xAA, then tag 1 data 0x11 → tag 1 commits first (WP1_DRindex = 5, WP1_Data = 0x11), tag 2 commits the next cycle; in-order retirement.
- Fill DEPTH = 15 entries → full = 1, alloc_ready = 0. Commit one, then allocate → new tag 1 (wrap skips 0).
- Lookup RP_ROBEN1 = 4 while CDB_valid with tag 4, data 0x55 → RP_ready1 = 1, RP_Data1 = 0x55 in the same cycle. RP_ROBEN2 = 0 → ready = 1.
- Entry with alloc_Wen = 0, or DRindex = 0, becomes ready → commit_valid = 1, WP1_Wen = 0, head advances.
- flush with 5 entries pending → next cycle empty = 1, head = tail = 1. Late CDB to old tag 3 is ignored. With ROB_STATS_EN defined, commit_count is retained.

Source files
------------

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// In-order commit queue for the out-of-order core. It hands out ROB tags
// (1..DEPTH; tag 0 means "value lives in the register file") to decoded
// instructions and captures results broadcast on the CDB. It retires the
// oldest entry through the register file's WP1 commit port.
//
// Optional feature: define ROB_STATS_EN to build a 32-bit retired-instruction
// counter on o_commit_count. Only reset clears it; flush does not. With the
// macro undefined, the output is tied to zero and no counter flop exists.
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int DEPTH = 15,
    parameter int TAG_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    // decode / allocation
    input  logic              i_alloc_req,
    input  logic              i_alloc_Wen,
    input  logic [4:0]        i_alloc_DRindex,
    output logic              o_alloc_ready,
    output logic              o_Decoded_WP1_Wen,
    output logic [TAG_W-1:0]  o_Decoded_WP1_ROBEN,
    output logic [4:0]        o_Decoded_WP1_DRindex,
    // common data bus
    input  logic              i_CDB_valid,
    input  logic [TAG_W-1:0]  i_CDB_ROBEN,
    input  logic [31:0]       i_CDB_Data,
    // operand lookup
    input  logic [TAG_W-1:0]  i_RP_ROBEN1,
    input  logic [TAG_W-1:0]  i_RP_ROBEN2,
    output logic              o_RP_ready1,
    output logic              o_RP_ready2,
    output logic [31:0]       o_RP_Data1,
    output logic [31:0]       o_RP_Data2,
    // commit
    output logic              o_commit_valid,
    output logic              o_WP1_Wen,
    output logic [TAG_W-1:0]  o_WP1_ROBEN,
    output logic [4:0]        o_WP1_DRindex,
    output logic [31:0]       o_WP1_Data,
    // status
    output logic              o_full,
    output logic              o_empty,
    output logic [TAG_W-1:0]  o_count,
    output logic [31:0]       o_commit_count
);

    // Every possible tag value gets a slot, so any TAG_W-bit tag indexes
    // the arrays without a range check. Slot 0 and slots above DEPTH are
    // never allocated, so their valid bits stay 0. Their lookups therefore
    // behave like lookups of an empty entry.
    localparam int               SLOTS     = 2 ** TAG_W;
    localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);
    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

    if (DEPTH < 2 || DEPTH > 31 || TAG_W != 5) begin : g_bad_param
        $error("reorder_buffer: DEPTH must be 2..31 and TAG_W must be 5");
    end

    // ---------------- state ----------------
    logic              r_valid   [SLOTS];
    logic              r_ready   [SLOTS];
    logic              r_wen     [SLOTS];
    logic [4:0]        r_dr      [SLOTS];
    logic [31:0]       r_data    [SLOTS];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W-1:0]  r_count;

    // ---------------- events of this cycle ----------------
    logic              w_full;
    logic              w_alloc;
    logic              w_cdb_hit;
    logic              w_commit;
    logic              w_discard;
    logic [TAG_W-1:0]  w_next_head;
    logic [TAG_W-1:0]  w_next_tail;

    // Tag successor: walk 1..DEPTH and skip tag 0 on the wrap.
    function automatic logic [TAG_W-1:0] f_next_tag(input logic [TAG_W-1:0] tag);
        return (tag == DEPTH_TAG) ? FIRST_TAG : tag + FIRST_TAG;
    endfunction

    assign w_full      = (r_count == DEPTH_TAG);
    assign w_discard   = i_rst || i_flush;
    // A slot freed by this cycle's commit is not offered to this cycle's
    // allocation. This keeps o_alloc_ready independent of the commit path.
    assign w_alloc     = i_alloc_req && !w_full;
    assign w_cdb_hit   = i_CDB_valid && r_valid[i_CDB_ROBEN] && !r_ready[i_CDB_ROBEN];
    assign w_commit    = r_valid[r_head] && r_ready[r_head];
    assign w_next_head = f_next_tag(r_head);
    assign w_next_tail = f_next_tag(r_tail);

    // ---------------- allocation port ----------------
    assign o_alloc_ready         = !w_full;
    assign o_Decoded_WP1_ROBEN   = r_tail;
    assign o_Decoded_WP1_DRindex = i_alloc_DRindex;
    assign o_Decoded_WP1_Wen     = w_alloc && i_alloc_Wen && (i_alloc_DRindex != 5'd0);

    // ---------------- commit port (registered state only) ----------------
    assign o_commit_valid = w_commit;
    assign o_WP1_Wen      = w_commit && r_wen[r_head] && (r_dr[r_head] != 5'd0);
    assign o_WP1_ROBEN    = r_head;
    assign o_WP1_DRindex  = r_dr[r_head];
    assign o_WP1_Data     = r_data[r_head];

    // ---------------- status ----------------
    assign o_full  = w_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Entry control bits and queue pointers: reset/flush clear, else alloc/CDB/commit.
    always_ff @(posedge i_clk) begin
        if (w_discard) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            r_head  <= FIRST_TAG;
            r_tail  <= FIRST_TAG;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Commit uses the
            // pre-edge head entry while allocation and CDB capture write other
            // slots at the same edge.
            // A valid head is never the tail unless full, and a full queue
            // cannot allocate. So alloc and commit never touch the same slot.
            // CDB capture needs !ready and commit needs ready, so those two
            // cannot collide either.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_wen[r_tail]   <= i_alloc_Wen;
                r_dr[r_tail]    <= i_alloc_DRindex;
                r_tail          <= w_next_tail;
            end
            if (w_cdb_hit) begin
                r_ready[i_CDB_ROBEN] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= w_next_head;
            end
            if (w_alloc && !w_commit) begin
                r_count <= r_count + FIRST_TAG;
            end else if (!w_alloc && w_commit) begin
                r_count <= r_count - FIRST_TAG;
            end
        end
    end

    // Result storage: written on CDB capture only.
    always_ff @(posedge i_clk) begin
        // NOTE: the data array has no reset. A slot's data is only
        // consumed once its ready bit, which is reset, says it was written.
        if (!w_discard && w_cdb_hit) begin
            r_data[i_CDB_ROBEN] <= i_CDB_Data;
        end
    end

    // Operand lookup port 1: tag 0, then CDB bypass, then stored entry.
    always_comb begin
        // NOTE: both outputs get a default first so no path infers a latch.
        o_RP_ready1 = r_ready[i_RP_ROBEN1];
        o_RP_Data1  = r_data[i_RP_ROBEN1];
        if (i_RP_ROBEN1 == '0) begin
            o_RP_ready1 = 1'b1;
            o_RP_Data1  = 32'd0;
        end else if (i_CDB_valid && (i_CDB_ROBEN == i_RP_ROBEN1)) begin
            o_RP_ready1 = 1'b1;
            o_RP_Data1  = i_CDB_Data;
        end
    end

    // Operand lookup port 2: same priority as port 1.
    always_comb begin
        o_RP_ready2 = r_ready[i_RP_ROBEN2];
        o_RP_Data2  = r_data[i_RP_ROBEN2];
        if (i_RP_ROBEN2 == '0) begin
            o_RP_ready2 = 1'b1;
            o_RP_Data2  = 32'd0;
        end else if (i_CDB_valid && (i_CDB_ROBEN == i_RP_ROBEN2)) begin
            o_RP_ready2 = 1'b1;
            o_RP_Data2  = i_CDB_Data;
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] r_commit_count;

    // Retired-instruction counter: cleared by reset only, holds across flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_commit_count <= '0;
        end else if (!i_flush && w_commit) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign o_commit_count = r_commit_count;
`else
    assign o_commit_count = 32'd0;
`endif

endmodule
